change_dispenser: RTL and testbench



---
 rtl/change_dispenser.sv | 174 +++++++++++++++++
 tb/tb_change_dispenser.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change-return unit: pays a nickel-unit amount as quarters, dimes and nickels
// (greedy), one hopper eject at a time, tracking tube inventory and jam faults.
module change_dispenser #(
  parameter int AMT_W   = 8,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 15,
  parameter int Q_INIT  = 20,
  parameter int D_INIT  = 20,
  parameter int N_INIT  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  input  logic             coin_ack,
  output logic             busy,
  output logic             eject_q,
  output logic             eject_d,
  output logic             eject_n,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remain,
  output logic             fault
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_WAIT_ACK, S_FAULT} state_e;
  typedef enum logic [1:0] {COIN_Q, COIN_D, COIN_N} coin_e;

  state_e           state_q, state_d;
  coin_e            sel_q, sel_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] q_cnt_q, q_cnt_d, d_cnt_q, d_cnt_d, n_cnt_q, n_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             busy_q, busy_d;
  logic             ej_qtr_q, ej_qtr_d, ej_dime_q, ej_dime_d, ej_nick_q, ej_nick_d;
  logic             done_q, done_d, short_q, short_d, fault_q, fault_d;
  logic [AMT_W-1:0] remain_q, remain_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= COIN_Q;
      rem_q     <= '0;
      q_cnt_q   <= CNT_W'(Q_INIT);
      d_cnt_q   <= CNT_W'(D_INIT);
      n_cnt_q   <= CNT_W'(N_INIT);
      timer_q   <= '0;
      busy_q    <= 1'b0;
      ej_qtr_q  <= 1'b0;
      ej_dime_q <= 1'b0;
      ej_nick_q <= 1'b0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      fault_q   <= 1'b0;
      remain_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rem_q     <= rem_d;
      q_cnt_q   <= q_cnt_d;
      d_cnt_q   <= d_cnt_d;
      n_cnt_q   <= n_cnt_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      ej_qtr_q  <= ej_qtr_d;
      ej_dime_q <= ej_dime_d;
      ej_nick_q <= ej_nick_d;
      done_q    <= done_d;
      short_q   <= short_d;
      fault_q   <= fault_d;
      remain_q  <= remain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rem_d     = rem_q;
    q_cnt_d   = q_cnt_q;
    d_cnt_d   = d_cnt_q;
    n_cnt_d   = n_cnt_q;
    timer_d   = timer_q;
    ej_qtr_d  = 1'b0;
    ej_dime_d = 1'b0;
    ej_nick_d = 1'b0;
    done_d    = 1'b0;
    short_d   = short_q;
    fault_d   = fault_q;
    remain_d  = remain_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          rem_d    = amount;
          short_d  = 1'b0;
          remain_d = '0;
          state_d  = S_SELECT;
        end else if (refill) begin
          q_cnt_d = CNT_W'(Q_INIT);
          d_cnt_d = CNT_W'(D_INIT);
          n_cnt_d = CNT_W'(N_INIT);
        end
      end

      S_SELECT: begin
        timer_d = '0;
        if (rem_q >= AMT_W'(5) && q_cnt_q != '0) begin
          sel_d    = COIN_Q;
          ej_qtr_d = 1'b1;
          state_d  = S_WAIT_ACK;
        end else if (rem_q >= AMT_W'(2) && d_cnt_q != '0) begin
          sel_d     = COIN_D;
          ej_dime_d = 1'b1;
          state_d   = S_WAIT_ACK;
        end else if (rem_q >= AMT_W'(1) && n_cnt_q != '0) begin
          sel_d     = COIN_N;
          ej_nick_d = 1'b1;
          state_d   = S_WAIT_ACK;
        end else begin
          done_d   = 1'b1;
          remain_d = rem_q;
          short_d  = (rem_q != '0);
          state_d  = S_IDLE;
        end
      end

      S_WAIT_ACK: begin
        if (coin_ack) begin
          case (sel_q)
            COIN_Q: begin
              rem_d   = rem_q - AMT_W'(5);
              q_cnt_d = q_cnt_q - CNT_W'(1);
            end
            COIN_D: begin
              rem_d   = rem_q - AMT_W'(2);
              d_cnt_d = d_cnt_q - CNT_W'(1);
            end
            default: begin
              rem_d   = rem_q - AMT_W'(1);
              n_cnt_d = n_cnt_q - CNT_W'(1);
            end
          endcase
          state_d = S_SELECT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Jam: the coin in flight stays counted in rem and in its tube.
          fault_d  = 1'b1;
          done_d   = 1'b1;
          short_d  = 1'b1;
          remain_d = rem_q;
          state_d  = S_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: ;
    endcase

    busy_d = (state_d == S_SELECT) || (state_d == S_WAIT_ACK);
  end

  assign busy    = busy_q;
  assign eject_q = ej_qtr_q;
  assign eject_d = ej_dime_q;
  assign eject_n = ej_nick_q;
  assign done    = done_q;
  assign short   = short_q;
  assign remain  = remain_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: three instances cover default inventory,
// an empty quarter tube, and fully empty tubes.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       req      [3];
  logic [7:0] amount   [3];
  logic       refill   [3];
  logic       coin_ack [3];
  logic       busy_w   [3];
  logic       ejq_w    [3];
  logic       ejd_w    [3];
  logic       ejn_w    [3];
  logic       done_w   [3];
  logic       short_w  [3];
  logic [7:0] remain_w [3];
  logic       fault_w  [3];

  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [6:0]  expq[$];

  always #5 clk = ~clk;

  change_dispenser u_dflt (
    .clk(clk), .rst(rst), .req(req[0]), .amount(amount[0]), .refill(refill[0]),
    .coin_ack(coin_ack[0]), .busy(busy_w[0]), .eject_q(ejq_w[0]), .eject_d(ejd_w[0]),
    .eject_n(ejn_w[0]), .done(done_w[0]), .short(short_w[0]), .remain(remain_w[0]),
    .fault(fault_w[0])
  );

  change_dispenser #(.Q_INIT(0)) u_noq (
    .clk(clk), .rst(rst), .req(req[1]), .amount(amount[1]), .refill(refill[1]),
    .coin_ack(coin_ack[1]), .busy(busy_w[1]), .eject_q(ejq_w[1]), .eject_d(ejd_w[1]),
    .eject_n(ejn_w[1]), .done(done_w[1]), .short(short_w[1]), .remain(remain_w[1]),
    .fault(fault_w[1])
  );

  change_dispenser #(.Q_INIT(0), .D_INIT(0), .N_INIT(0)) u_empty (
    .clk(clk), .rst(rst), .req(req[2]), .amount(amount[2]), .refill(refill[2]),
    .coin_ack(coin_ack[2]), .busy(busy_w[2]), .eject_q(ejq_w[2]), .eject_d(ejd_w[2]),
    .eject_n(ejn_w[2]), .done(done_w[2]), .short(short_w[2]), .remain(remain_w[2]),
    .fault(fault_w[2])
  );

  // Output bundle: {busy, eject_q, eject_d, eject_n, done, short, fault}
  function automatic logic [6:0] vec(input int i);
    return {busy_w[i], ejq_w[i], ejd_w[i], ejn_w[i], done_w[i], short_w[i], fault_w[i]};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks expq cycle by cycle after a req; ackm/reqm bit c drives coin_ack/req after cycle c.
  task automatic check_seq(input int i, input string tag,
                           input logic [15:0] ackm, input logic [15:0] reqm);
    for (int c = 1; c <= expq.size(); c++) begin
      cyc();
      chk($sformatf("%s_c%0d", tag, c), 32'(vec(i)), 32'(expq[c-1]));
      req[i]      = reqm[c];
      if (reqm[c]) amount[i] = 8'd9;
      coin_ack[i] = ackm[c];
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; amount[i] = '0; refill[i] = 1'b0; coin_ack[i] = 1'b0;
    end
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_vec%0d", i), 32'(vec(i)), 0);
      chk($sformatf("reset_remain%0d", i), 32'(remain_w[i]), 0);
    end

    // amount=8 -> Q, D, N with ack on each eject cycle; done at cycle 8
    cyc();
    req[0] = 1'b1; amount[0] = 8'd8;
    expq = {7'b1000000, 7'b1100000, 7'b1000000, 7'b1010000,
            7'b1000000, 7'b1001000, 7'b1000000, 7'b0000100};
    check_seq(0, "qdn", 16'b0000_0000_0101_0100, 16'h0);
    chk("qdn_remain", 32'(remain_w[0]), 0);

    // amount=4 with a req(9) and stray ack during SELECT -> two dimes only
    cyc();
    req[0] = 1'b1; amount[0] = 8'd4;
    expq = {7'b1000000, 7'b1010000, 7'b1000000, 7'b1010000,
            7'b1000000, 7'b0000100, 7'b0000000};
    check_seq(0, "busyreq", 16'b0000_0000_0001_0110, 16'b0000_0000_0000_0010);
    chk("busyreq_remain", 32'(remain_w[0]), 0);

    // amount=10, reset after first coin acked, then amount=5 from reloaded tubes
    cyc();
    req[0] = 1'b1; amount[0] = 8'd10;
    expq = {7'b1000000, 7'b1100000, 7'b1000000};
    check_seq(0, "midrst", 16'b0000_0000_0000_0100, 16'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_vec", 32'(vec(0)), 0);
    chk("midrst_remain", 32'(remain_w[0]), 0);
    req[0] = 1'b1; amount[0] = 8'd5;
    expq = {7'b1000000, 7'b1100000, 7'b1000000, 7'b0000100};
    check_seq(0, "after_rst", 16'b0000_0000_0000_0100, 16'h0);
    chk("after_rst_remain", 32'(remain_w[0]), 0);

    // amount=5, never acked -> jam after 15 WAIT_ACK cycles
    cyc();
    req[0] = 1'b1; amount[0] = 8'd5;
    cyc();
    chk("jam_c1", 32'(vec(0)), 32'(7'b1000000));
    req[0] = 1'b0;
    cyc();
    chk("jam_c2", 32'(vec(0)), 32'(7'b1100000));
    for (int c = 3; c <= 16; c++) begin
      cyc();
      chk($sformatf("jam_wait_c%0d", c), 32'(vec(0)), 32'(7'b1000000));
    end
    cyc();
    chk("jam_fault", 32'(vec(0)), 32'(7'b0000111));
    chk("jam_remain", 32'(remain_w[0]), 5);
    cyc();
    chk("jam_hold", 32'(vec(0)), 32'(7'b0000011));
    req[0] = 1'b1; amount[0] = 8'd3; coin_ack[0] = 1'b1; refill[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk($sformatf("fault_absorb%0d", c), 32'(vec(0)), 32'(7'b0000011));
      chk($sformatf("fault_remain%0d", c), 32'(remain_w[0]), 5);
    end
    req[0] = 1'b0; coin_ack[0] = 1'b0; refill[0] = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("fault_cleared", 32'(vec(0)), 0);
    chk("fault_cleared_remain", 32'(remain_w[0]), 0);

    // Q_INIT=0, amount=5 -> D, D, N
    cyc();
    req[1] = 1'b1; amount[1] = 8'd5;
    expq = {7'b1000000, 7'b1010000, 7'b1000000, 7'b1010000,
            7'b1000000, 7'b1001000, 7'b1000000, 7'b0000100};
    check_seq(1, "noq", 16'b0000_0000_0101_0100, 16'h0);
    chk("noq_remain", 32'(remain_w[1]), 0);

    // empty tubes, amount=3 -> immediate short of 3; refill to zero changes nothing
    cyc();
    req[2] = 1'b1; amount[2] = 8'd3;
    expq = {7'b1000000, 7'b0000110};
    check_seq(2, "empty", 16'h0, 16'h0);
    chk("empty_remain", 32'(remain_w[2]), 3);
    refill[2] = 1'b1;
    cyc();
    refill[2] = 1'b0;
    chk("empty_hold", 32'(vec(2)), 32'(7'b0000010));
    chk("empty_hold_remain", 32'(remain_w[2]), 3);
    req[2] = 1'b1; amount[2] = 8'd3;
    expq = {7'b1000000, 7'b0000110};
    check_seq(2, "empty_refill", 16'h0, 16'h0);
    chk("empty_refill_remain", 32'(remain_w[2]), 3);

    // amount=0 -> done at cycle 2, not short
    cyc();
    req[0] = 1'b1; amount[0] = 8'd0;
    expq = {7'b1000000, 7'b0000100};
    check_seq(0, "zero", 16'h0, 16'h0);
    chk("zero_remain", 32'(remain_w[0]), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
